// File: rtl/dcache_dataarray_ctrl.sv
// Sequencer/arbiter for the 2-way, 8-bank dcache data array: shares the single write port
// between refill beats and masked stores, and the read port between evictions and loads.
module dcache_dataarray_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      refill_req_valid,
  output logic                      refill_req_ready,
  input  logic                      refill_way,
  input  logic [ADDR_WIDTH-1:0]     refill_index,
  input  logic                      refill_beat_valid,
  output logic                      refill_beat_ready,
  input  logic [DATA_WIDTH-1:0]     refill_beat_data,
  input  logic                      store_valid,
  output logic                      store_ready,
  input  logic                      store_way,
  input  logic [ADDR_WIDTH-1:0]     store_index,
  input  logic [2:0]                store_bank,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic [DATA_WIDTH-1:0]     store_wmask,
  input  logic                      evict_req_valid,
  output logic                      evict_req_ready,
  input  logic                      evict_way,
  input  logic [ADDR_WIDTH-1:0]     evict_index,
  output logic                      evict_resp_valid,
  input  logic                      evict_resp_ready,
  output logic [8*DATA_WIDTH-1:0]   evict_resp_data,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [ADDR_WIDTH-1:0]     load_index,
  output logic                      load_resp_valid,
  output logic [8*DATA_WIDTH-1:0]   load_resp_way0,
  output logic [8*DATA_WIDTH-1:0]   load_resp_way1,
  output logic [7:0]                we_way0,
  output logic [7:0]                ce_way0,
  output logic [7:0]                we_way1,
  output logic [7:0]                ce_way1,
  output logic [ADDR_WIDTH-1:0]     writewayaddr_way0,
  output logic [ADDR_WIDTH-1:0]     writewayaddr_way1,
  output logic [ADDR_WIDTH-1:0]     readwayaddr_way0,
  output logic [ADDR_WIDTH-1:0]     readwayaddr_way1,
  output logic [8*DATA_WIDTH-1:0]   din_flat,
  output logic [8*DATA_WIDTH-1:0]   wmask_flat,
  input  logic [8*DATA_WIDTH-1:0]   dout_way0_flat,
  input  logic [8*DATA_WIDTH-1:0]   dout_way1_flat
);
  localparam int LINE_WIDTH = 8 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    EVICT_RD  = 2'd2,
    EVICT_RSP = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [2:0]              beat_cnt_r;
  logic                    way_r;
  logic [ADDR_WIDTH-1:0]   index_r;
  logic [LINE_WIDTH-1:0]   evict_buf_r;
  logic                    load_resp_valid_r;

  logic idle_s, refill_acc_s, evict_acc_s, store_acc_s, beat_acc_s, load_ready_s, load_acc_s;

  // Exactly one IDLE request wins: refill over evict over store.
  assign idle_s       = (state_r == IDLE) && !reset;
  assign refill_acc_s = idle_s && refill_req_valid;
  assign evict_acc_s  = idle_s && !refill_req_valid && evict_req_valid;
  assign store_acc_s  = idle_s && !refill_req_valid && !evict_req_valid && store_valid;
  assign beat_acc_s   = (state_r == REFILL) && !reset && refill_beat_valid;
  assign load_ready_s = !reset && !evict_acc_s;
  assign load_acc_s   = load_valid && load_ready_s;

  assign refill_req_ready  = refill_acc_s;
  assign evict_req_ready   = evict_acc_s;
  assign store_ready       = store_acc_s;
  assign refill_beat_ready = (state_r == REFILL) && !reset;
  assign load_ready        = load_ready_s;
  assign evict_resp_valid  = (state_r == EVICT_RSP) && !reset;
  assign evict_resp_data   = evict_buf_r;
  assign load_resp_valid   = load_resp_valid_r && !reset;
  assign load_resp_way0    = dout_way0_flat;
  assign load_resp_way1    = dout_way1_flat;

  logic                    wen_s, wway_s;
  logic [2:0]              wbank_s;
  logic [DATA_WIDTH-1:0]   wdata_s, wmask_word_s;
  logic [ADDR_WIDTH-1:0]   waddr_s;
  logic [7:0]              wsel_s;
  logic [LINE_WIDTH-1:0]   din_s, wmask_s;

  // Write-port source select: a refill beat or a single-bank store.
  always_comb begin
    wen_s        = 1'b0;
    wway_s       = way_r;
    wbank_s      = beat_cnt_r;
    wdata_s      = refill_beat_data;
    wmask_word_s = {DATA_WIDTH{1'b1}};
    waddr_s      = index_r;
    if (beat_acc_s) begin
      wen_s = 1'b1;
    end else if (store_acc_s) begin
      wen_s        = 1'b1;
      wway_s       = store_way;
      wbank_s      = store_bank;
      wdata_s      = store_data;
      wmask_word_s = store_wmask;
      waddr_s      = store_index;
    end else begin
      wen_s = 1'b0;
    end
  end

  assign wsel_s = wen_s ? (8'b0000_0001 << wbank_s) : 8'h00;

  // Place the write word and mask into the selected bank lane.
  always_comb begin
    din_s   = {LINE_WIDTH{1'b0}};
    wmask_s = {LINE_WIDTH{1'b0}};
    for (int b = 0; b < 8; b++) begin
      if (wsel_s[b]) begin
        din_s[b*DATA_WIDTH +: DATA_WIDTH]   = wdata_s;
        wmask_s[b*DATA_WIDTH +: DATA_WIDTH] = wmask_word_s;
      end else begin
        din_s[b*DATA_WIDTH +: DATA_WIDTH]   = {DATA_WIDTH{1'b0}};
        wmask_s[b*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  logic [7:0]            rce0_s, rce1_s;
  logic [ADDR_WIDTH-1:0] raddr_s;

  // Read-port select: an eviction read one way, a load reads both ways.
  always_comb begin
    rce0_s  = 8'h00;
    rce1_s  = 8'h00;
    raddr_s = index_r;
    if (evict_acc_s) begin
      raddr_s = evict_index;
      if (evict_way) begin
        rce1_s = 8'hFF;
      end else begin
        rce0_s = 8'hFF;
      end
    end else if (load_acc_s) begin
      raddr_s = load_index;
      rce0_s  = 8'hFF;
      rce1_s  = 8'hFF;
    end else begin
      raddr_s = index_r;
    end
  end

  assign we_way0           = wway_s ? 8'h00 : wsel_s;
  assign we_way1           = wway_s ? wsel_s : 8'h00;
  assign ce_way0           = we_way0 | rce0_s;
  assign ce_way1           = we_way1 | rce1_s;
  assign writewayaddr_way0 = waddr_s;
  assign writewayaddr_way1 = waddr_s;
  assign readwayaddr_way0  = raddr_s;
  assign readwayaddr_way1  = raddr_s;
  assign din_flat          = din_s;
  assign wmask_flat        = wmask_s;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (refill_acc_s) begin
          state_s = REFILL;
        end else if (evict_acc_s) begin
          state_s = EVICT_RD;
        end else begin
          state_s = IDLE;
        end
      end
      REFILL: begin
        if (beat_acc_s && (beat_cnt_r == 3'd7)) begin
          state_s = IDLE;
        end else begin
          state_s = REFILL;
        end
      end
      EVICT_RD:  state_s = EVICT_RSP;
      EVICT_RSP: begin
        if (evict_resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = EVICT_RSP;
        end
      end
      default:   state_s = IDLE;
    endcase
  end

  // State, beat counter, latched target and victim buffer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r           <= IDLE;
      beat_cnt_r        <= 3'd0;
      way_r             <= 1'b0;
      index_r           <= {ADDR_WIDTH{1'b0}};
      evict_buf_r       <= {LINE_WIDTH{1'b0}};
      load_resp_valid_r <= 1'b0;
    end else begin
      state_r           <= state_s;
      load_resp_valid_r <= load_acc_s;
      if (refill_acc_s) begin
        way_r      <= refill_way;
        index_r    <= refill_index;
        beat_cnt_r <= 3'd0;
      end else if (evict_acc_s) begin
        way_r   <= evict_way;
        index_r <= evict_index;
      end else if (beat_acc_s) begin
        beat_cnt_r <= beat_cnt_r + 3'd1;
      end
      // Array data for the eviction read arrives the cycle after the address.
      if (state_r == EVICT_RD) begin
        evict_buf_r <= way_r ? dout_way1_flat : dout_way0_flat;
      end
    end
  end
endmodule

// File: tb/tb_dcache_dataarray_ctrl.sv
// Directed bench for dcache_dataarray_ctrl with a behavioural 2-way x 8-bank data-array model.
module tb_dcache_dataarray_ctrl;
  localparam int DW = 64;
  localparam int AW = 9;
  localparam int LW = 8 * DW;

  logic          clock, reset;
  logic          refill_req_valid, refill_req_ready, refill_way;
  logic [AW-1:0] refill_index;
  logic          refill_beat_valid, refill_beat_ready;
  logic [DW-1:0] refill_beat_data;
  logic          store_valid, store_ready, store_way;
  logic [AW-1:0] store_index;
  logic [2:0]    store_bank;
  logic [DW-1:0] store_data, store_wmask;
  logic          evict_req_valid, evict_req_ready, evict_way;
  logic [AW-1:0] evict_index;
  logic          evict_resp_valid, evict_resp_ready;
  logic [LW-1:0] evict_resp_data;
  logic          load_valid, load_ready;
  logic [AW-1:0] load_index;
  logic          load_resp_valid;
  logic [LW-1:0] load_resp_way0, load_resp_way1;
  logic [7:0]    we_way0, ce_way0, we_way1, ce_way1;
  logic [AW-1:0] writewayaddr_way0, writewayaddr_way1, readwayaddr_way0, readwayaddr_way1;
  logic [LW-1:0] din_flat, wmask_flat;
  logic [LW-1:0] dout_way0_flat, dout_way1_flat;

  int tests  = 0;
  int errors = 0;

  dcache_dataarray_ctrl dut (
    .clock(clock), .reset(reset),
    .refill_req_valid(refill_req_valid), .refill_req_ready(refill_req_ready),
    .refill_way(refill_way), .refill_index(refill_index),
    .refill_beat_valid(refill_beat_valid), .refill_beat_ready(refill_beat_ready),
    .refill_beat_data(refill_beat_data),
    .store_valid(store_valid), .store_ready(store_ready), .store_way(store_way),
    .store_index(store_index), .store_bank(store_bank), .store_data(store_data),
    .store_wmask(store_wmask),
    .evict_req_valid(evict_req_valid), .evict_req_ready(evict_req_ready),
    .evict_way(evict_way), .evict_index(evict_index),
    .evict_resp_valid(evict_resp_valid), .evict_resp_ready(evict_resp_ready),
    .evict_resp_data(evict_resp_data),
    .load_valid(load_valid), .load_ready(load_ready), .load_index(load_index),
    .load_resp_valid(load_resp_valid), .load_resp_way0(load_resp_way0),
    .load_resp_way1(load_resp_way1),
    .we_way0(we_way0), .ce_way0(ce_way0), .we_way1(we_way1), .ce_way1(ce_way1),
    .writewayaddr_way0(writewayaddr_way0), .writewayaddr_way1(writewayaddr_way1),
    .readwayaddr_way0(readwayaddr_way0), .readwayaddr_way1(readwayaddr_way1),
    .din_flat(din_flat), .wmask_flat(wmask_flat),
    .dout_way0_flat(dout_way0_flat), .dout_way1_flat(dout_way1_flat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Array model: synchronous read (pre-write data on collision), bit-masked write.
  logic [DW-1:0] mem0 [8][512];
  logic [DW-1:0] mem1 [8][512];
  logic          mem_clear;

  always @(posedge clock) begin
    if (mem_clear) begin
      for (int b = 0; b < 8; b++)
        for (int a = 0; a < 512; a++) begin
          mem0[b][a] <= '0;
          mem1[b][a] <= '0;
        end
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (ce_way0[b]) dout_way0_flat[b*DW +: DW] <= mem0[b][readwayaddr_way0];
        if (ce_way1[b]) dout_way1_flat[b*DW +: DW] <= mem1[b][readwayaddr_way1];
        if (ce_way0[b] && we_way0[b])
          mem0[b][writewayaddr_way0] <= (mem0[b][writewayaddr_way0] & ~wmask_flat[b*DW +: DW])
                                        | (din_flat[b*DW +: DW] & wmask_flat[b*DW +: DW]);
        if (ce_way1[b] && we_way1[b])
          mem1[b][writewayaddr_way1] <= (mem1[b][writewayaddr_way1] & ~wmask_flat[b*DW +: DW])
                                        | (din_flat[b*DW +: DW] & wmask_flat[b*DW +: DW]);
      end
    end
  end

  typedef struct packed {
    logic       rv, ev, sv, lv, eway, sway;
    logic [2:0] sbank;
    logic [3:0] exp_rdy;   // {refill, evict, store, load}
    logic [7:0] exp_we0, exp_we1, exp_ce0, exp_ce1;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_valids();
    refill_req_valid  = 1'b0;
    refill_beat_valid = 1'b0;
    store_valid       = 1'b0;
    evict_req_valid   = 1'b0;
    load_valid        = 1'b0;
  endtask

  function automatic logic [LW-1:0] ramp_line(input logic [DW-1:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < 8; i++) l[i*DW +: DW] = base + DW'(i);
    return l;
  endfunction

  initial begin
    logic [LW-1:0] exp_line;
    logic [7:0]    exp_sel;
    int            b;

    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,4'b0001,8'h00,8'h00,8'h00,8'h00};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,3'd0,4'b0001,8'h00,8'h00,8'hFF,8'hFF};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,4'b0011,8'h01,8'h00,8'h01,8'h00};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,3'd7,4'b0011,8'h00,8'h80,8'h00,8'h80};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,3'd0,4'b0100,8'h00,8'h00,8'h00,8'hFF};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,3'd0,4'b0100,8'h00,8'h00,8'hFF,8'h00};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,3'd3,4'b0100,8'h00,8'h00,8'h00,8'hFF};
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,4'b1001,8'h00,8'h00,8'hFF,8'hFF};
    vecs[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,4'b1001,8'h00,8'h00,8'h00,8'h00};
    vecs[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,3'd2,4'b0011,8'h04,8'h00,8'hFF,8'hFF};
    vecs[10] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,3'd4,4'b0100,8'h00,8'h00,8'hFF,8'h00};

    mem_clear = 1'b1;
    reset = 1'b1;
    clear_valids();
    evict_resp_ready = 1'b0;
    refill_way = 1'b0; refill_index = '0; refill_beat_data = '0;
    store_way = 1'b0; store_index = '0; store_bank = 3'd0; store_data = '0; store_wmask = '0;
    evict_way = 1'b0; evict_index = '0; load_index = '0;

    // Reset: every ready/enable/valid stays low even with all requests asserted.
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      refill_req_valid = 1'b1; refill_beat_valid = 1'b1; store_valid = 1'b1;
      evict_req_valid = 1'b1; load_valid = 1'b1;
      #1;
      check($sformatf("reset_outputs%0d", c),
            LW'({refill_req_ready, refill_beat_ready, store_ready, evict_req_ready, load_ready,
                 evict_resp_valid, load_resp_valid, we_way0, we_way1, ce_way0, ce_way1}), '0);
    end
    @(negedge clock);
    clear_valids();
    reset = 1'b0;
    mem_clear = 1'b0;

    // IDLE arbitration table: inputs withdrawn before the edge so nothing is accepted.
    store_index = 9'd20; evict_index = 9'd30; load_index = 9'd40;
    store_data = 64'h5; store_wmask = 64'hF;
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      refill_req_valid = vecs[i].rv; evict_req_valid = vecs[i].ev;
      store_valid = vecs[i].sv; load_valid = vecs[i].lv;
      evict_way = vecs[i].eway; store_way = vecs[i].sway; store_bank = vecs[i].sbank;
      #1;
      check($sformatf("idle_vec%0d", i),
            LW'({refill_req_ready, evict_req_ready, store_ready, load_ready,
                 we_way0, we_way1, ce_way0, ce_way1}),
            LW'({vecs[i].exp_rdy, vecs[i].exp_we0, vecs[i].exp_we1, vecs[i].exp_ce0, vecs[i].exp_ce1}));
      #1;
      clear_valids();
    end

    // Store way1 idx5 bank3, low-byte mask.
    @(negedge clock);
    store_valid = 1'b1; store_way = 1'b1; store_index = 9'd5; store_bank = 3'd3;
    store_data = 64'h1111_2222_3333_4444; store_wmask = 64'hFF;
    #1;
    check("store1_ready", LW'(store_ready), LW'(1'b1));
    check("store1_we", LW'({we_way0, we_way1}), LW'(16'h0008));
    check("store1_addr", LW'(writewayaddr_way1), LW'(9'd5));
    check("store1_wmask", wmask_flat, LW'(64'hFF) << 192);
    // Store way1 idx7 bank2, full mask (line later evicted).
    @(negedge clock);
    store_index = 9'd7; store_bank = 3'd2;
    store_data = 64'hDEAD_BEEF_0123_4567; store_wmask = '1;
    #1;
    check("store2_we", LW'({we_way0, we_way1}), LW'(16'h0004));
    check("store2_din", LW'(din_flat[2*DW +: DW]), LW'(64'hDEAD_BEEF_0123_4567));

    // Refill, evict and store all valid at once: only the refill is taken.
    @(negedge clock);
    refill_req_valid = 1'b1; refill_way = 1'b0; refill_index = 9'h1A0;
    evict_req_valid = 1'b1; evict_way = 1'b1; evict_index = 9'd7;
    store_valid = 1'b1; store_way = 1'b0; store_index = 9'd9; store_bank = 3'd1;
    store_data = 64'hCAFE; store_wmask = '1;
    #1;
    check("prio_readies", LW'({refill_req_ready, evict_req_ready, store_ready}), LW'(3'b100));

    // Eight beats with a gap after beat 3; a load to way1 idx5 rides along.
    b = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      refill_req_valid = 1'b0;
      load_valid = (c == 6); load_index = 9'd5;
      refill_beat_valid = (c != 4);
      refill_beat_data = 64'h100 + DW'(b);
      #1;
      check($sformatf("refill_rdy_c%0d", c),
            LW'({refill_beat_ready, evict_req_ready, store_ready}), LW'(3'b100));
      if (c == 4) begin
        check("refill_gap_we", LW'({we_way0, we_way1}), '0);
      end else begin
        exp_sel = 8'h01 << b;
        check($sformatf("refill_we_b%0d", b), LW'({we_way0, we_way1}), LW'({exp_sel, 8'h00}));
        check($sformatf("refill_din_b%0d", b), LW'(din_flat[b*DW +: DW]), LW'(64'h100 + DW'(b)));
        check($sformatf("refill_addr_b%0d", b), LW'(writewayaddr_way0), LW'(9'h1A0));
        b++;
      end
      if (c == 6) check("refill_load_ready", LW'(load_ready), LW'(1'b1));
      if (c == 7) begin
        check("refill_load_resp_valid", LW'(load_resp_valid), LW'(1'b1));
        check("refill_load_resp_data", load_resp_way1, LW'(64'h44) << 192);
      end
      if (c == 8) check("refill_load_resp_drop", LW'(load_resp_valid), LW'(1'b0));
    end

    // Refill done: evict wins next; a concurrent load is refused.
    @(negedge clock);
    refill_beat_valid = 1'b0;
    load_valid = 1'b1; load_index = 9'h1A0;
    #1;
    check("evict_accept", LW'({evict_req_ready, store_ready, refill_beat_ready, load_ready}),
          LW'(4'b1000));
    check("evict_ce", LW'({ce_way0, ce_way1}), LW'(16'h00FF));
    check("evict_raddr", LW'(readwayaddr_way1), LW'(9'd7));
    @(negedge clock);
    load_valid = 1'b0;
    #1;
    check("evict_rd", LW'({evict_resp_valid, store_ready, load_resp_valid}), '0);
    exp_line = '0;
    exp_line[2*DW +: DW] = 64'hDEAD_BEEF_0123_4567;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      evict_resp_ready = (c == 3);
      #1;
      check($sformatf("evict_rsp_valid%0d", c), LW'({evict_resp_valid, store_ready}), LW'(2'b10));
      check($sformatf("evict_rsp_data%0d", c), evict_resp_data, exp_line);
    end
    // Back in IDLE the blocked store finally goes.
    @(negedge clock);
    evict_resp_ready = 1'b0; evict_req_valid = 1'b0;
    #1;
    check("store3_accept", LW'({store_ready, evict_resp_valid, we_way0, we_way1}),
          LW'({2'b10, 8'h02, 8'h00}));
    check("store3_addr", LW'(writewayaddr_way0), LW'(9'd9));
    @(negedge clock);
    store_valid = 1'b0;
    load_valid = 1'b1; load_index = 9'h1A0;
    #1;
    check("load_ready", LW'({load_ready, ce_way0, ce_way1}), LW'({1'b1, 16'hFFFF}));
    check("load_raddr", LW'(readwayaddr_way0), LW'(9'h1A0));
    @(negedge clock);
    load_valid = 1'b0;
    #1;
    check("load_resp_valid", LW'(load_resp_valid), LW'(1'b1));
    check("load_resp_refill_line", load_resp_way0, ramp_line(64'h100));

    // Reset after five beats abandons the refill; a new one starts at bank 0.
    @(negedge clock);
    refill_req_valid = 1'b1; refill_way = 1'b1; refill_index = 9'h033;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      refill_req_valid = 1'b0; refill_beat_valid = 1'b1;
      refill_beat_data = 64'h200 + DW'(i);
    end
    @(negedge clock);
    refill_beat_valid = 1'b0; reset = 1'b1;
    #1;
    check("midreset_outputs", LW'({refill_beat_ready, we_way1, ce_way1}), '0);
    @(negedge clock);
    reset = 1'b0;
    refill_req_valid = 1'b1;
    #1;
    check("midreset_idle", LW'({refill_req_ready, refill_beat_ready}), LW'(2'b10));
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      refill_req_valid = 1'b0; refill_beat_valid = 1'b1;
      refill_beat_data = 64'h300 + DW'(i);
      #1;
      exp_sel = 8'h01 << i;
      check($sformatf("rerefill_we_b%0d", i), LW'({we_way0, we_way1}), LW'({8'h00, exp_sel}));
    end
    @(negedge clock);
    refill_beat_valid = 1'b0;
    load_valid = 1'b1; load_index = 9'h033;
    #1;
    check("rerefill_idle", LW'({refill_beat_ready, load_ready}), LW'(2'b01));
    @(negedge clock);
    load_valid = 1'b0;
    #1;
    check("rerefill_line", load_resp_way1, ramp_line(64'h300));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/dcache_dataarray_ctrl.md
Name: dcache_dataarray_ctrl

Overview:
- Sequencer and arbiter in front of the 2-way, 8-bank dcache data array. Each bank is 64 bits wide; a full 512-bit line spans bank0..bank7 at one index.
- Shares the array's single write port between line refills (8 memory beats) and single-bank masked stores.
- Shares the read port between victim-line eviction reads and load lookups.
- Sits between the dcache miss/store logic and the data array.

Parameters:
DATA_WIDTH, 64, width of one bank word / one refill beat
ADDR_WIDTH, 9, set index width

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
refill_req_valid/refill_req_ready  in/out  1/1  refill start handshake
refill_way  in  1  target way
refill_index  in  ADDR_WIDTH  target set
refill_beat_valid/refill_beat_ready  in/out  1/1  beat handshake
refill_beat_data  in  DATA_WIDTH  beat data; beat n goes to bank n
store_valid/store_ready  in/out  1/1  store handshake
store_way  in  1  store way
store_index  in  ADDR_WIDTH  store set
store_bank  in  3  store bank
store_data  in  DATA_WIDTH  store data
store_wmask  in  DATA_WIDTH  per-bit write mask
evict_req_valid/evict_req_ready  in/out  1/1  eviction read request
evict_way  in  1  eviction way
evict_index  in  ADDR_WIDTH  eviction set
evict_resp_valid/evict_resp_ready  out/in  1/1  victim line handshake
evict_resp_data  out  8*DATA_WIDTH  victim line, bank0 in LSBs
load_valid/load_ready  in/out  1/1  load lookup handshake
load_index  in  ADDR_WIDTH  load set
load_resp_valid  out  1  load data valid
load_resp_way0/load_resp_way1  out  8*DATA_WIDTH  both ways' lines
we_way0/ce_way0/we_way1/ce_way1  out  8 each  per-bank write / chip enables
writewayaddr_way0/writewayaddr_way1  out  ADDR_WIDTH  write index
readwayaddr_way0/readwayaddr_way1  out  ADDR_WIDTH  read index
din_flat  out  8*DATA_WIDTH  write data, bank i at [i*DATA_WIDTH +: DATA_WIDTH], same for both ways
wmask_flat  out  8*DATA_WIDTH  write mask, same layout
dout_way0_flat/dout_way1_flat  in  8*DATA_WIDTH  array read data, valid 1 cycle after the read address

Behaviour:
- FSM states: IDLE, REFILL, EVICT_RD, EVICT_RSP. Registers: state, beat_cnt[2:0], latched way/index, evict buffer, load_resp_valid.
- Reset: state=IDLE, beat_cnt=0, evict buffer cleared. All *_ready, we_*, ce_*, evict_resp_valid and load_resp_valid are 0 while reset is high. Reset mid-refill or mid-evict abandons the operation; partially written banks are not rolled back.
- IDLE priority: refill > evict > store. Exactly one of the three readies is high, only for the highest-priority valid request.
  - Refill accept: latch way/index, beat_cnt=0, go to REFILL.
  - Evict accept: drive readwayaddr_way0/1=evict_index, set ce=8'hFF on evict_way, go to EVICT_RD.
  - Store accept: single cycle. we/ce=1 only on store_bank of store_way, writewayaddr=store_index, din/wmask placed at store_bank. Stay in IDLE.
- REFILL: refill_beat_ready=1. On each beat handshake, write bank beat_cnt of the latched way at the latched index with an all-ones mask, then beat_cnt++. The handshake with beat_cnt==7 returns to IDLE next cycle. Beat gaps are allowed. Store and evict readies are 0.
- EVICT_RD: capture dout of the latched way into the evict buffer, go to EVICT_RSP.
- EVICT_RSP: evict_resp_valid=1 and data held stable. On evict_resp_ready, return to IDLE. No new evict or refill is accepted until then; stores are blocked.
- Loads: load_ready=1 except when reset is high or in the IDLE cycle an evict is accepted (read port busy).
  - Load accept: readwayaddr_way0/1=load_index, ce=8'hFF on both ways.
  - Next cycle: load_resp_valid=1 and load_resp_way0/1 = dout passthrough. There is no backpressure on the response.
  - Loads run in parallel with refill and stores.
- Same-index read and write in one cycle: the read returns the pre-write data. Coherence is the requester's responsibility.
- Unused ce/we bits are 0. Addresses and din hold their last values when idle (don't-care).

Test Plan:
- Reset, then idle: all readies/we/ce=0 during reset. After release, store_ready=1 for one cycle with store_valid=1, way1, idx 5, bank 3, mask 0xFF → we_way1=8'h08, writewayaddr_way1=5.
- Refill way0 idx 0x1A0 with beats 0x100..0x107, one gap cycle after beat 3 → we_way0 walks 8'h01..8'h80 skipping the gap. State returns to IDLE after 8 beats. A following load idx 0x1A0 returns bank i = 0x100+i.
- Simultaneous refill_req, evict_req and store valid in IDLE → only refill_req_ready=1. Evict is accepted the cycle after refill finishes; store is accepted after evict_resp handshakes.
- Evict way1 idx 7 → ce_way1=8'hFF in issue cycle. evict_resp_valid rises 2 cycles later and holds 3 cycles with ready low; data equals the line written earlier.
- Load issued in the evict-accept cycle → load_ready=0. Load issued during REFILL → load_resp_valid exactly 1 cycle later.
- Assert reset after refill beat 4 → next cycle IDLE, beat_cnt=0. A new refill restarts at bank 0.
